// File: rtl/pci_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pci_bus_initiator : PCI bus-master request/arbitration and burst engine  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pci_bus_initiator #(
  parameter int MAX_LEN        = 8,
  parameter int LAT_TIMER      = 16,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  status,
  output logic [3:0]  xfer_cnt,
  output logic        req,
  input  logic        GNT,
  input  logic        frame_in,
  input  logic        IRDY_in,
  output logic        frame_out,
  output logic        frame_oe,
  output logic        IRDY_out,
  output logic        IRDY_oe,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  input  logic [31:0] ad_in,
  output logic [3:0]  cbe_out,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        STOP
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_LAST = 3'd4,
    S_TURN = 3'd5
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_STOP  = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;
  localparam logic [1:0] ST_LAT   = 2'b11;
  localparam logic [3:0] MAX_L    = 4'(MAX_LEN);
  localparam logic [7:0] LAT_LIM  = 8'(LAT_TIMER);
  localparam logic [8:0] DSEL_LIM = 9'(DEVSEL_TIMEOUT);

  state_t      state_q, state_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  ph_q, ph_d;
  logic        dsel_ok_q, dsel_ok_d;
  logic [1:0]  res_q, res_d;
  logic [1:0]  status_q;
  logic [3:0]  xfer_q;
  logic        wr_pop_q, rd_valid_q;
  logic [31:0] rd_data_q;

  logic        xfer_done;
  logic        last_ph;
  logic        f_abort, f_stop, f_lat;
  logic [3:0]  remaining;

  assign remaining = len_q - cnt_q;
  assign last_ph   = (remaining <= 4'd1);
  // ph_q counts clocks elapsed since the start of the address phase
  assign f_abort   = !dsel_ok_q && DEVSEL && (({1'b0, ph_q} + 9'd1) >= DSEL_LIM);
  assign f_stop    = !STOP;
  assign f_lat     = (ph_q >= LAT_LIM) && GNT;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    dsel_ok_d = dsel_ok_q;
    res_d     = res_q;
    xfer_done = 1'b0;
    cmd_ready = 1'b0;
    req       = 1'b1;
    frame_oe  = 1'b0;
    frame_out = 1'b1;
    IRDY_oe   = 1'b0;
    IRDY_out  = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = 32'd0;
    cbe_out   = 4'b0000;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = S_REQ;
          cnt_d   = 4'd0;
          res_d   = ST_OK;
        end
      end
      S_REQ: begin
        req = 1'b0;
        if (!GNT && frame_in && IRDY_in) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        frame_oe  = 1'b1;
        frame_out = 1'b0;
        ad_oe     = 1'b1;
        ad_out    = addr_q;
        cbe_out   = write_q ? 4'b0111 : 4'b0110;
        ph_d      = 8'd1;
        dsel_ok_d = !DEVSEL;
        state_d   = S_DATA;
      end
      S_DATA: begin
        frame_oe  = 1'b1;
        frame_out = last_ph;
        IRDY_oe   = 1'b1;
        IRDY_out  = 1'b0;
        ad_oe     = write_q;
        ad_out    = write_q ? wr_data : 32'd0;
        if (ph_q != 8'hFF) ph_d = ph_q + 8'd1;
        if (!DEVSEL) dsel_ok_d = 1'b1;
        xfer_done = !TRDY && !f_abort;
        if (xfer_done) cnt_d = cnt_q + 4'd1;
        if (f_abort || f_stop || f_lat) begin
          res_d   = f_abort ? ST_ABORT : (f_stop ? ST_STOP : ST_LAT);
          state_d = last_ph ? S_TURN : S_LAST;
        end else if (xfer_done && last_ph) begin
          state_d = S_TURN;
        end
      end
      S_LAST: begin
        frame_oe = 1'b1;
        IRDY_oe  = 1'b1;
        IRDY_out = 1'b0;
        ad_oe    = write_q;
        ad_out   = write_q ? wr_data : 32'd0;
        if (res_q == ST_ABORT) begin
          state_d = S_TURN;
        end else if (!TRDY) begin
          xfer_done = 1'b1;
          cnt_d     = cnt_q + 4'd1;
          state_d   = S_TURN;
        end else if (!STOP) begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        frame_oe = 1'b1;
        IRDY_oe  = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      len_q      <= 4'd1;
      cnt_q      <= 4'd0;
      ph_q       <= 8'd0;
      dsel_ok_q  <= 1'b0;
      res_q      <= ST_OK;
      status_q   <= ST_OK;
      xfer_q     <= 4'd0;
      wr_pop_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      dsel_ok_q  <= dsel_ok_d;
      res_q      <= res_d;
      wr_pop_q   <= xfer_done && write_q;
      rd_valid_q <= xfer_done && !write_q;
      if (xfer_done && !write_q) rd_data_q <= ad_in;
      if (state_q == S_IDLE && cmd_valid) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        len_q   <= (cmd_len == 4'd0) ? 4'd1 : ((cmd_len > MAX_L) ? MAX_L : cmd_len);
      end
      if (state_d == S_TURN) begin
        status_q <= res_d;
        xfer_q   <= cnt_d;
      end
    end
  end

  assign wr_pop   = wr_pop_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign status   = status_q;
  assign xfer_cnt = xfer_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pci_bus_initiator : table-driven bench with a behavioural PCI target  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pci_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid, done;
  logic [1:0]  status;
  logic [3:0]  xfer_cnt;
  logic        req, GNT, frame_in, IRDY_in;
  logic        frame_out, frame_oe, IRDY_out, IRDY_oe;
  logic [31:0] ad_out, ad_in;
  logic        ad_oe;
  logic [3:0]  cbe_out;
  logic        TRDY, DEVSEL, STOP;

  always #5 clk = ~clk;

  pci_bus_initiator #(.MAX_LEN(8), .LAT_TIMER(4), .DEVSEL_TIMEOUT(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .status(status), .xfer_cnt(xfer_cnt),
    .req(req), .GNT(GNT), .frame_in(frame_in), .IRDY_in(IRDY_in),
    .frame_out(frame_out), .frame_oe(frame_oe), .IRDY_out(IRDY_out), .IRDY_oe(IRDY_oe),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .cbe_out(cbe_out),
    .TRDY(TRDY), .DEVSEL(DEVSEL), .STOP(STOP)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  len;
    int          gnt_dly;
    int          trdy_wait;
    bit          devsel_on;
    int          stop_word;
    bit          stop_trdy;
    bit          gnt_drop;
    logic [1:0]  exp_status;
    int          exp_xfer;
    int          exp_rel;
    int          exp_done;
  } vec_t;

  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_q[$];
  int          wr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  addr_k, rel, frame_rel, done_k, words, wait_cnt, wr_idx, pulses;
    bit  stopped, finished, drive_bad;
    addr_k = -1; frame_rel = -1; done_k = -1;
    words = 0; wait_cnt = 0; wr_idx = 0; pulses = 0;
    stopped = 0; finished = 0; drive_bad = 0;
    wr_data = 32'h5000_0000;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 80 && !finished; k++) begin
      @(negedge clk);
      if (wr_pop) begin
        pulses++;
        if (wr_q.size() == 0) chk("wr_pop_spurious", 1'b1, 1'b0);
        else chk("wr_pop_order", wr_idx, wr_q.pop_front());
        wr_idx++;
        wr_data = 32'h5000_0000 + wr_idx;
      end
      if (rd_valid) begin
        pulses++;
        if (rd_q.size() == 0) chk("rd_valid_spurious", 1'b1, 1'b0);
        else chk("rd_data", rd_data, rd_q.pop_front());
      end
      #1;
      rel = (addr_k >= 0) ? k - addr_k : -1;
      if (addr_k < 0 && frame_oe && !frame_out && !IRDY_oe) begin
        addr_k = k; rel = 0;
        chk("addr_ad", ad_out, v.addr);
        chk("addr_cbe_req", {cbe_out, ad_oe, req}, {(v.wr ? 4'b0111 : 4'b0110), 1'b1, 1'b1});
      end
      if (addr_k >= 0 && frame_rel < 0 && frame_oe && frame_out) frame_rel = rel;
      GNT = (k < v.gnt_dly) || (v.gnt_drop && addr_k >= 0 && rel >= 2);
      TRDY = 1'b1; STOP = 1'b1; DEVSEL = 1'b1;
      if (done) begin
        done_k = rel;
        finished = 1;
        chk("turn_drive", {frame_oe, frame_out, IRDY_oe, IRDY_out, ad_oe}, 5'b11110);
        chk("status", status, v.exp_status);
        chk("xfer_cnt", xfer_cnt, v.exp_xfer);
      end else if (IRDY_oe && !IRDY_out) begin
        if (ad_oe !== v.wr || cbe_out !== 4'b0000) drive_bad = 1;
        DEVSEL = !v.devsel_on;
        if (v.devsel_on) begin
          if (stopped) STOP = 1'b0;
          else if (wait_cnt >= v.trdy_wait) begin
            if (words + 1 == v.stop_word) begin
              STOP = 1'b0; TRDY = !v.stop_trdy; stopped = 1;
            end else TRDY = 1'b0;
          end
        end
        ad_in = 32'hA000_0000 ^ (v.addr + words);
        if (!TRDY) begin
          if (v.wr) begin
            if (ad_out !== 32'h5000_0000 + words) drive_bad = 1;
            wr_q.push_back(words);
          end else rd_q.push_back(ad_in);
          words++;
          wait_cnt = 0;
        end else wait_cnt++;
      end else if (addr_k >= 0 && rel >= 1) begin
        drive_bad = 1;
      end
    end
    chk("finished", finished, 1'b1);
    chk("frame_release", frame_rel, v.exp_rel);
    chk("done_cycle", done_k, v.exp_done);
    chk("data_drive", drive_bad, 1'b0);
    chk("pulses", pulses, v.exp_xfer);
    chk("sb_empty", rd_q.size() + wr_q.size(), 0);
    rd_q.delete(); wr_q.delete();
    GNT = 1'b1;
    @(negedge clk);
    chk("back_idle", {cmd_ready, frame_oe, IRDY_oe, ad_oe, done}, 5'b10000);
  endtask

  initial begin
    //          wr    addr           len   gd tw dv sw st dr  status  xf rel done
    vecs[0] = '{1'b1, 32'h1000_0000, 4'd4, 0, 0, 1, 0, 0, 0, 2'b00, 4, 4, 5};
    vecs[1] = '{1'b0, 32'h2000_0040, 4'd2, 3, 2, 1, 0, 0, 0, 2'b00, 2, 4, 7};
    vecs[2] = '{1'b1, 32'h3000_0000, 4'd4, 0, 0, 0, 0, 0, 0, 2'b10, 0, 5, 6};
    vecs[3] = '{1'b0, 32'h4000_0000, 4'd8, 0, 0, 1, 3, 1, 0, 2'b01, 3, 4, 5};
    vecs[4] = '{1'b1, 32'h5000_0100, 4'd8, 0, 0, 1, 3, 0, 0, 2'b01, 2, 4, 5};
    vecs[5] = '{1'b1, 32'h6000_0000, 4'd8, 0, 3, 1, 0, 0, 1, 2'b11, 2, 5, 9};
    vecs[6] = '{1'b1, 32'h7000_0000, 4'd1, 0, 1, 1, 0, 0, 0, 2'b00, 1, 1, 3};
    vecs[7] = '{1'b0, 32'h7100_0000, 4'd0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 1, 2};
    vecs[8] = '{1'b0, 32'h8000_0000, 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 8, 8, 9};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 4'd0;
    wr_data = 32'd0; GNT = 1'b1; frame_in = 1'b1; IRDY_in = 1'b1; ad_in = 32'd0;
    TRDY = 1'b1; DEVSEL = 1'b1; STOP = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state",
        {req, frame_oe, IRDY_oe, ad_oe, frame_out, IRDY_out, cmd_ready, done, wr_pop, rd_valid, status, xfer_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0});

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Bus busy while granted, then reset in the middle of a data phase
    begin
      bit got, seen;
      got = 0; seen = 0;
      frame_in = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9000_0000; cmd_len = 4'd2;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      GNT = 1'b0;
      repeat (4) @(negedge clk);
      chk("req_hold_busy", {req, frame_oe, cmd_ready}, 3'b000);
      frame_in = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (frame_oe && !frame_out) got = 1;
      end
      chk("t6_addr", got, 1'b1);
      @(negedge clk);
      DEVSEL = 1'b0;
      @(negedge clk);
      chk("t6_in_data", {IRDY_oe, IRDY_out}, 2'b10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release", {req, frame_oe, IRDY_oe, ad_oe, done, cmd_ready, status, xfer_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0});
      rst = 1'b0; DEVSEL = 1'b1; GNT = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done || wr_pop || frame_oe) seen = 1;
      end
      chk("rst_no_done", seen, 1'b0);
    end

    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
